// File: rtl/tone_decoder_pkg.sv
// Shared definitions for the tone receive path: note codes, reference periods,
// FSM encoding and the period classifier.
package tone_pkg;
  localparam int CNT_W = 28;
  localparam logic [3:0] NOTE_NONE = 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCKED} state_e;

  // Full-period cycle counts at 50 MHz, codes 1..12 = C5..B5 (same table as the generator).
  function automatic logic [CNT_W-1:0] ref_period(input logic [3:0] code);
    case (code)
      4'd1:    return 28'd95_602;
      4'd2:    return 28'd90_253;
      4'd3:    return 28'd85_179;
      4'd4:    return 28'd80_386;
      4'd5:    return 28'd75_873;
      4'd6:    return 28'd71_633;
      4'd7:    return 28'd67_568;
      4'd8:    return 28'd63_776;
      4'd9:    return 28'd60_168;
      4'd10:   return 28'd56_818;
      4'd11:   return 28'd53_648;
      4'd12:   return 28'd50_607;
      default: return '0;
    endcase
  endfunction

  // Scanned high to low so the lowest matching code is the one that sticks.
  function automatic logic [3:0] classify(input logic [CNT_W-1:0] period,
                                          input int tol_shift, input int ref_shift);
    logic [3:0]       code;
    logic [CNT_W-1:0] ref_p, tol, diff;
    code = NOTE_NONE;
    for (int k = 12; k >= 1; k--) begin
      ref_p = ref_period(4'(k)) >> ref_shift;
      tol   = ref_p >> tol_shift;
      diff  = (period >= ref_p) ? period - ref_p : ref_p - period;
      if (diff <= tol) code = 4'(k);
    end
    return code;
  endfunction
endpackage

// File: rtl/tone_decoder_if.sv
// Control/result bundle between the tone decoder and its user.
interface tone_decoder_if;
  import tone_pkg::*;
  logic             Enable;
  logic             Tone_in;
  logic [3:0]       Note_code;
  logic [CNT_W-1:0] Note_dur;
  logic             Note_valid;
  logic             Locked;

  modport master (output Enable, Tone_in, input Note_code, Note_dur, Note_valid, Locked);
  modport slave  (input Enable, Tone_in, output Note_code, Note_dur, Note_valid, Locked);
endinterface

// File: rtl/tone_decoder_period_meter.sv
// Synchronizes the external square wave, detects rising edges and measures
// the cycle count between consecutive edges.
module tone_period_meter
  import tone_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             tone_in,
  output logic             rise,
  output logic [CNT_W-1:0] period
);
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] per_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign rise   = sync_q[1] & ~sync_q[2];
  assign period = per_cnt;

  // per_cnt reads P on the edge cycle because it restarts at 1 right after the previous edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      sync_q  <= '0;
      per_cnt <= '0;
    end else begin
      sync_q  <= {sync_q[1:0], tone_in};
      per_cnt <= rise ? CNT_W'(1) : sat_inc(per_cnt);
    end
  end
endmodule

// File: rtl/tone_decoder.sv
// Classifies the measured tone period into a note, tracks note changes and
// reports each finished note with its duration in clock cycles.
module tone_decoder
  import tone_pkg::*;
#(
  parameter logic [CNT_W-1:0] SILENCE_CYC = 28'd2_500_000,
  parameter int               STABLE_N    = 4,
  parameter int               TOL_SHIFT   = 5,
  parameter int               REF_SHIFT   = 0
)(
  input  logic          Clock,
  input  logic          Reset_n,
  tone_decoder_if.slave bus
);
  logic             clr, rise, timeout;
  logic [CNT_W-1:0] period;
  logic [3:0]       code_c;

  state_e           state, state_n;
  logic [3:0]       cur, cur_n, cand, cand_n, alt_code, alt_code_n;
  logic [3:0]       match_cnt, match_n, alt_cnt, alt_n, alt_new;
  logic [CNT_W-1:0] dur_cnt, dur_base, last_ts, last_ts_n, alt_ts, alt_ts_n;
  logic             emit, note_valid_q;
  logic [3:0]       emit_code, note_code_q;
  logic [CNT_W-1:0] emit_dur, note_dur_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign clr     = !Reset_n || !bus.Enable;
  assign code_c  = classify(period, TOL_SHIFT, REF_SHIFT);
  assign timeout = period > SILENCE_CYC;

  tone_period_meter u_meter (
    .clk    (Clock),
    .clr    (clr),
    .tone_in(bus.Tone_in),
    .rise   (rise),
    .period (period)
  );

  // dur_base is the note timestamp of the current cycle; the register holds it plus one.
  always_comb begin
    state_n    = state;
    cur_n      = cur;
    cand_n     = cand;
    alt_code_n = alt_code;
    match_n    = match_cnt;
    alt_n      = alt_cnt;
    alt_new    = alt_cnt;
    last_ts_n  = last_ts;
    alt_ts_n   = alt_ts;
    dur_base   = dur_cnt;
    emit       = 1'b0;
    emit_code  = cur;
    emit_dur   = last_ts;
    case (state)
      S_IDLE: begin
        if (rise) begin
          state_n  = S_ACQ;
          dur_base = '0;
          match_n  = '0;
        end
      end
      S_ACQ: begin
        if (rise) begin
          if (code_c != NOTE_NONE && (match_cnt == '0 || code_c == cand)) begin
            cand_n  = code_c;
            match_n = match_cnt + 4'd1;
            if (match_cnt + 4'd1 == 4'(STABLE_N)) begin
              state_n   = S_LOCKED;
              cur_n     = code_c;
              last_ts_n = dur_cnt;
              alt_n     = '0;
              match_n   = '0;
            end
          end else if (code_c != NOTE_NONE) begin
            // New candidate: its note began at the previous edge, P cycles ago.
            cand_n   = code_c;
            match_n  = 4'd1;
            dur_base = period;
          end else begin
            match_n  = '0;
            dur_base = '0;
          end
        end else if (timeout) begin
          state_n = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (rise) begin
          if (code_c == cur) begin
            last_ts_n = dur_cnt;
            alt_n     = '0;
          end else begin
            if (alt_cnt == '0 || code_c != alt_code) begin
              alt_new    = 4'd1;
              alt_code_n = code_c;
              if (alt_cnt == '0) alt_ts_n = last_ts;
            end else begin
              alt_new = alt_cnt + 4'd1;
            end
            alt_n = alt_new;
            if (alt_new == 4'(STABLE_N)) begin
              emit     = 1'b1;
              emit_dur = alt_ts;
              alt_n    = '0;
              if (code_c != NOTE_NONE) begin
                // Rebase so the new note's origin is the edge where the old one ended.
                cur_n     = code_c;
                dur_base  = dur_cnt - alt_ts;
                last_ts_n = dur_cnt - alt_ts;
              end else begin
                state_n = S_IDLE;
              end
            end
          end
        end else if (timeout) begin
          emit    = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (clr) begin
      state        <= S_IDLE;
      cur          <= NOTE_NONE;
      cand         <= NOTE_NONE;
      alt_code     <= NOTE_NONE;
      match_cnt    <= '0;
      alt_cnt      <= '0;
      dur_cnt      <= '0;
      last_ts      <= '0;
      alt_ts       <= '0;
      note_valid_q <= 1'b0;
      note_code_q  <= NOTE_NONE;
      note_dur_q   <= '0;
    end else begin
      state        <= state_n;
      cur          <= cur_n;
      cand         <= cand_n;
      alt_code     <= alt_code_n;
      match_cnt    <= match_n;
      alt_cnt      <= alt_n;
      dur_cnt      <= sat_inc(dur_base);
      last_ts      <= last_ts_n;
      alt_ts       <= alt_ts_n;
      note_valid_q <= emit;
      if (emit) begin
        note_code_q <= emit_code;
        note_dur_q  <= emit_dur;
      end
    end
  end

  assign bus.Note_valid = note_valid_q;
  assign bus.Note_code  = note_code_q;
  assign bus.Note_dur   = note_dur_q;
  assign bus.Locked     = (state == S_LOCKED);
endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder: reference periods are scaled down by 2^7 and
// the silence timeout shortened so whole songs fit in a short run.
module tb_tone_decoder;
  import tone_pkg::*;

  localparam logic [CNT_W-1:0] SIL = 28'd2000;
  localparam int RSH = 7;
  localparam int PA  = 443;  // 56_818 >> 7 (A5)
  localparam int PC  = 746;  // 95_602 >> 7 (C5)
  localparam int PX  = 1000; // outside every scaled note band
  localparam int PG  = 156;  // 20_000 >> 7, glitch period

  typedef struct packed {
    logic [3:0]       code;
    logic [CNT_W-1:0] dur;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tone_decoder_if bus ();

  tone_decoder #(
    .SILENCE_CYC(SIL),
    .STABLE_N   (4),
    .TOL_SHIFT  (5),
    .REF_SHIFT  (RSH)
  ) dut (
    .Clock  (clk),
    .Reset_n(rst_n),
    .bus    (bus)
  );

  ev_t exp_q[$];
  ev_t got_ev;
  int  checks = 0;
  int  passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // Scoreboard: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.Note_valid === 1'b1) begin
      check("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        got_ev = exp_q.pop_front();
        check("note_code", 32'(bus.Note_code), 32'(got_ev.code));
        check("note_dur", 32'(bus.Note_dur), 32'(got_ev.dur));
      end
    end
  end

  // Rising edge now, next rising edge p cycles later; called on a negedge.
  task automatic pulse(input int p);
    bus.Tone_in = 1'b1;
    repeat (p / 2) @(negedge clk);
    bus.Tone_in = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  task automatic quiet();
    repeat (int'(SIL) + 40) @(negedge clk);
  endtask

  task automatic drained(input string tag);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  int jit_sum;
  int jp;

  initial begin
    bus.Enable  = 1'b1;
    bus.Tone_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bus.Note_valid), 32'd0);
    check("rst_locked", 32'(bus.Locked), 32'd0);
    check("rst_code", 32'(bus.Note_code), 32'd0);
    check("rst_dur", 32'(bus.Note_dur), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single A5 note, ended by silence.
    exp_q.push_back('{code: 4'd10, dur: 28'(7 * PA)});
    for (int i = 0; i < 4; i++) pulse(PA);
    check("a5_unlocked_before_5th", 32'(bus.Locked), 32'd0);
    pulse(PA);
    check("a5_locked_after_5th", 32'(bus.Locked), 32'd1);
    for (int i = 0; i < 3; i++) pulse(PA);
    quiet();
    check("a5_unlocked_after_silence", 32'(bus.Locked), 32'd0);
    drained("a5_drained");

    // A5 then C5: the change edge closes A5 and opens C5.
    exp_q.push_back('{code: 4'd10, dur: 28'(5 * PA)});
    exp_q.push_back('{code: 4'd1, dur: 28'(5 * PC)});
    for (int i = 0; i < 5; i++) pulse(PA);
    for (int i = 0; i < 6; i++) pulse(PC);
    check("a5c5_locked_on_c5", 32'(bus.Locked), 32'd1);
    quiet();
    drained("a5c5_drained");

    // Reset while locked on A5: everything clears, nothing reported.
    for (int i = 0; i < 6; i++) pulse(PA);
    check("pre_reset_locked", 32'(bus.Locked), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_valid", 32'(bus.Note_valid), 32'd0);
    check("reset_locked", 32'(bus.Locked), 32'd0);
    check("reset_code", 32'(bus.Note_code), 32'd0);
    check("reset_dur", 32'(bus.Note_dur), 32'd0);
    rst_n = 1'b1;
    quiet();
    drained("reset_no_event");

    // Unknown period never locks.
    for (int i = 0; i < 10; i++) begin
      pulse(PX);
      check("unknown_never_locks", 32'(bus.Locked), 32'd0);
    end
    quiet();
    drained("unknown_no_event");

    // Jittered A5 still locks; duration is the sum of the measured periods.
    jit_sum = 0;
    for (int i = 0; i < 8; i++) begin
      jp = PA - 7 + int'($urandom_range(0, 14));
      if (i < 7) jit_sum += jp;
      if (i == 7) exp_q.push_back('{code: 4'd10, dur: 28'(jit_sum)});
      pulse(jp);
    end
    check("jitter_locked", 32'(bus.Locked), 32'd1);
    quiet();
    drained("jitter_drained");

    // One short foreign period inside an A5 note is ignored.
    exp_q.push_back('{code: 4'd10, dur: 28'(9 * PA + PG)});
    for (int i = 0; i < 5; i++) pulse(PA);
    pulse(PG);
    for (int i = 0; i < 5; i++) pulse(PA);
    check("glitch_still_locked", 32'(bus.Locked), 32'd1);
    quiet();
    drained("glitch_single_event");

    // Enable low mid-note behaves like reset.
    for (int i = 0; i < 6; i++) pulse(PA);
    bus.Enable = 1'b0;
    @(negedge clk);
    check("disable_locked", 32'(bus.Locked), 32'd0);
    check("disable_valid", 32'(bus.Note_valid), 32'd0);
    bus.Enable = 1'b1;
    quiet();
    drained("disable_no_event");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
